dcache_direct_mapped: RTL

- Data cache between the CPU's 8-bit load/store port and the 32-bit block-wide data memory.
- Direct-mapped, 8 blocks of 4 bytes, write-back, write-allocate.
- Converts CPU byte READ/WRITE requests into block reads and writes to memory.
- Stalls the CPU through BUSYWAIT while a miss is serviced.

---
 rtl/dcache_direct_mapped_if.sv | 28 ++
 rtl/dcache_direct_mapped.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dcache_direct_mapped_if.sv
// Bus bundles for the direct-mapped data cache: CPU byte port and memory block port.
// Signal names follow the existing CPU/memory netlist.

interface dcache_cpu_if;
   logic       READ;
   logic       WRITE;
   logic [7:0] ADDRESS;
   logic [7:0] WRITE_DATA;
   logic [7:0] READ_DATA;
   logic       BUSYWAIT;

   modport master (output READ, WRITE, ADDRESS, WRITE_DATA, input READ_DATA, BUSYWAIT);
   modport slave  (input READ, WRITE, ADDRESS, WRITE_DATA, output READ_DATA, BUSYWAIT);
endinterface

interface dcache_mem_if;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;

   modport master (output mem_read, mem_write, mem_address, mem_writedata,
                   input mem_readdata, mem_busywait);
   modport slave  (input mem_read, mem_write, mem_address, mem_writedata,
                   output mem_readdata, mem_busywait);
endinterface

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate data cache: 8 lines of 4 bytes,
// byte-wide CPU side, block-wide memory side, stalls the CPU while a miss is serviced.

module dcache_direct_mapped (
   input  logic         CLK,
   input  logic         RESET,
   dcache_cpu_if.slave  cpu_bus,
   dcache_mem_if.master mem_bus
);

   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_e;

   state_e      state_q;
   logic        valid_q [8];
   logic        dirty_q [8];
   logic [2:0]  tag_q   [8];
   logic [31:0] data_q  [8];

   logic [2:0]  miss_tag_q;
   logic [2:0]  miss_idx_q;
   logic [31:0] fill_q;

   logic        mem_read_q;
   logic        mem_write_q;
   logic [5:0]  mem_address_q;
   logic [31:0] mem_writedata_q;

   logic [2:0]  addr_tag;
   logic [2:0]  addr_idx;
   logic [1:0]  addr_off;
   logic [31:0] cur_line;
   logic [31:0] line_wdata_d;
   logic        req;
   logic        hit;

   assign addr_tag = cpu_bus.ADDRESS[7:5];
   assign addr_idx = cpu_bus.ADDRESS[4:2];
   assign addr_off = cpu_bus.ADDRESS[1:0];
   assign cur_line = data_q[addr_idx];
   assign req      = cpu_bus.READ | cpu_bus.WRITE;
   assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

   assign cpu_bus.BUSYWAIT  = req && !(state_q == IDLE && hit);
   assign cpu_bus.READ_DATA = cur_line[{addr_off, 3'b000} +: 8];

   // Store-hit merge: the addressed byte of the current line replaced by the CPU byte.
   always_comb begin
      line_wdata_d = cur_line;
      line_wdata_d[{addr_off, 3'b000} +: 8] = cpu_bus.WRITE_DATA;
   end

   assign mem_bus.mem_read      = mem_read_q;
   assign mem_bus.mem_write     = mem_write_q;
   assign mem_bus.mem_address   = mem_address_q;
   assign mem_bus.mem_writedata = mem_writedata_q;

   // NOTE: all state, including the line storage, is updated with non-blocking
   // assignments so every read in this block sees pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q         <= IDLE;
         miss_tag_q      <= '0;
         miss_idx_q      <= '0;
         fill_q          <= '0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_address_q   <= '0;
         mem_writedata_q <= '0;
         // NOTE: the storage is a flop array, not a RAM, so clearing it on reset
         // is legal and required for a deterministic empty cache.
         for (int i = 0; i < 8; i++) begin
            valid_q[i] <= 1'b0;
            dirty_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            data_q[i]  <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (req && !hit) begin
                  miss_tag_q <= addr_tag;
                  miss_idx_q <= addr_idx;
                  if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
                     state_q         <= WRITEBACK;
                     mem_write_q     <= 1'b1;
                     mem_address_q   <= {tag_q[addr_idx], addr_idx};
                     mem_writedata_q <= cur_line;
                  end else begin
                     state_q       <= FETCH;
                     mem_read_q    <= 1'b1;
                     mem_address_q <= cpu_bus.ADDRESS[7:2];
                  end
               end else if (cpu_bus.WRITE && hit) begin
                  // WRITE wins over a simultaneous READ.
                  data_q[addr_idx]  <= line_wdata_d;
                  dirty_q[addr_idx] <= 1'b1;
               end
            end
            WRITEBACK: begin
               if (!mem_bus.mem_busywait) begin
                  state_q       <= FETCH;
                  mem_write_q   <= 1'b0;
                  mem_read_q    <= 1'b1;
                  mem_address_q <= {miss_tag_q, miss_idx_q};
               end
            end
            FETCH: begin
               if (!mem_bus.mem_busywait) begin
                  state_q    <= UPDATE;
                  mem_read_q <= 1'b0;
                  fill_q     <= mem_bus.mem_readdata;
               end
            end
            UPDATE: begin
               state_q             <= IDLE;
               data_q[miss_idx_q]  <= fill_q;
               tag_q[miss_idx_q]   <= miss_tag_q;
               valid_q[miss_idx_q] <= 1'b1;
               dirty_q[miss_idx_q] <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
